// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Pipeline stage register for the CPU datapath.
//                Two-entry skid buffer (main slot M, skid slot S) with a
//                valid/ready handshake on both sides. It also provides stall
//                and flush control, bubble-safe control output and a
//                saturating bubble counter.
//  Ports       : clk        - rising-edge clock
//                rst        - asynchronous reset, active-low (0 = reset)
//                in_valid   - upstream presents an entry
//                in_ready   - stage can accept an entry (registered)
//                in_data    - upstream data payload   [DATA_W]
//                in_ctrl    - upstream control payload [CTRL_W]
//                stall      - hold the head entry, no dequeue
//                flush      - discard every held entry (sync, top priority)
//                out_valid  - stage presents an entry downstream
//                out_ready  - downstream accepts the entry
//                out_data   - data of the head entry   [DATA_W]
//                out_ctrl   - control of head entry, 0 when no entry [CTRL_W]
//                occupancy  - number of held entries (0..2)
//                bubble_cnt - saturating count of bubble cycles [CNT_W]
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  // Slot storage
  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic              r_s_valid;
  logic [DATA_W-1:0] r_s_data;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic [1:0]        r_occ;
  logic [CNT_W-1:0]  r_bubble_cnt;

  // Handshake and next-state wires
  logic w_accept;
  logic w_drain;
  logic w_bubble;
  logic w_m_valid_nxt;
  logic w_s_valid_nxt;
  logic w_m_load_in;
  logic w_m_load_s;
  logic w_s_load_in;

  // in_ready depends only on a register, so there is no combinational
  // path from out_ready back to in_ready.
  assign w_accept = in_valid & ~r_s_valid;
  assign w_drain  = r_m_valid & out_ready & ~stall;
  assign w_bubble = ~r_m_valid & out_ready & ~stall;

  always_comb begin
    w_m_valid_nxt = r_m_valid;
    w_s_valid_nxt = r_s_valid;
    w_m_load_in   = 1'b0;
    w_m_load_s    = 1'b0;
    w_s_load_in   = 1'b0;
    if (flush) begin
      // Offered input is dropped along with every held entry.
      w_m_valid_nxt = 1'b0;
      w_s_valid_nxt = 1'b0;
    end else if (!r_m_valid) begin
      // S is never occupied while M is empty, so an arrival always lands
      // in M, even during a stall, so that no accepted entry is lost.
      if (w_accept) begin
        w_m_valid_nxt = 1'b1;
        w_m_load_in   = 1'b1;
      end
    end else if (w_drain) begin
      if (r_s_valid) begin
        // S refills M; in_ready was 0 so no accept is possible here.
        w_m_load_s    = 1'b1;
        w_s_valid_nxt = 1'b0;
      end else if (w_accept) begin
        w_m_load_in   = 1'b1;
      end else begin
        w_m_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      // M is held (backpressure or stall): park the arrival in S.
      w_s_valid_nxt = 1'b1;
      w_s_load_in   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_ctrl     <= '0;
      r_s_valid    <= 1'b0;
      r_s_data     <= '0;
      r_s_ctrl     <= '0;
      r_occ        <= 2'd0;
      r_bubble_cnt <= '0;
    end else begin
      r_m_valid <= w_m_valid_nxt;
      r_s_valid <= w_s_valid_nxt;
      r_occ     <= {1'b0, w_m_valid_nxt} + {1'b0, w_s_valid_nxt};
      if (w_m_load_in) begin
        r_m_data <= in_data;
        r_m_ctrl <= in_ctrl;
      end else if (w_m_load_s) begin
        r_m_data <= r_s_data;
        r_m_ctrl <= r_s_ctrl;
      end
      if (w_s_load_in) begin
        r_s_data <= in_data;
        r_s_ctrl <= in_ctrl;
      end
      if (w_bubble && (r_bubble_cnt != c_cnt_max)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready   = ~r_s_valid;
  assign out_valid  = r_m_valid;
  assign out_data   = r_m_data;
  // Gate control so no write enable leaks out of an empty or flushed slot.
  assign out_ctrl   = r_m_valid ? r_m_ctrl : '0;
  assign occupancy  = r_occ;
  assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire
